// File: rtl/cpu5_enc_pkg.sv
// cpu5_enc_pkg: descriptor kinds, RV32I opcodes and the NOP word shared by the encoder
package cpu5_enc_pkg;
   typedef enum logic [3:0] {
      K_R      = 4'd0,
      K_OPIMM  = 4'd1,
      K_LOAD   = 4'd2,
      K_STORE  = 4'd3,
      K_BRANCH = 4'd4,
      K_JAL    = 4'd5,
      K_JALR   = 4'd6,
      K_LUI    = 4'd7,
      K_AUIPC  = 4'd8
   } enc_kind_t;
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [31:0] NOP      = 32'h0000_0013;
endpackage

// File: rtl/cpu5_instr_encoder_if.sv
// cpu5_instr_encoder_if: descriptor input stream, word output stream and address control
interface cpu5_instr_encoder_if #(parameter int ADDR_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_kind;
   logic [2:0]        in_funct3;
   logic              in_alt;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              addr_load;
   logic [ADDR_W-1:0] addr_val;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;
   logic [7:0]        err_cnt;
   modport master (
      output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
             addr_load, addr_val, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
   );
   modport slave (
      input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
             addr_load, addr_val, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
   );
endinterface

// File: rtl/cpu5_enc_pack.sv
// cpu5_enc_pack: packs one descriptor into an RV32I word; CPU5_ENC_RANGE_CHECK_EN adds immediate range checks
module cpu5_enc_pack
   import cpu5_enc_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        illegal
);
   logic        shift;
   logic        bad;
   logic        range_bad;
   logic [31:0] raw;
   assign shift = kind == K_OPIMM && (funct3 == 3'd1 || funct3 == 3'd5);
   // field placement per instruction format
   always_comb begin
      raw = NOP;
      case (kind)
         K_R:      raw = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
         K_OPIMM:  raw = shift ? {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_OPIMM}
                                : {imm[11:0], rs1, funct3, rd, OP_OPIMM};
         K_LOAD:   raw = {imm[11:0], rs1, funct3, rd, OP_LOAD};
         K_STORE:  raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
         K_BRANCH: raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
         K_JAL:    raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         K_JALR:   raw = {imm[11:0], rs1, funct3, rd, OP_JALR};
         K_LUI:    raw = {imm[19:0], rd, OP_LUI};
         K_AUIPC:  raw = {imm[19:0], rd, OP_AUIPC};
         default:  raw = NOP;
      endcase
   end
   assign bad = kind > 4'd8
             || (kind == K_LOAD && (funct3 == 3'd3 || funct3[2:1] == 2'b11))
             || (kind == K_STORE && funct3 > 3'd2)
             || (kind == K_BRANCH && funct3[2:1] == 2'b01)
             || (kind == K_JALR && funct3 != 3'd0)
             || (alt && kind == K_R && funct3 != 3'd0 && funct3 != 3'd5)
             || (alt && kind == K_OPIMM && funct3 != 3'd5)
             || (shift && imm[31:5] != 27'd0);
`ifdef CPU5_ENC_RANGE_CHECK_EN
   logic signed [31:0] s;
   logic               i_out;
   assign s = imm;
   assign i_out = s < -32'sd2048 || s > 32'sd2047;
   assign range_bad = (((kind == K_OPIMM && !shift) || kind == K_LOAD || kind == K_JALR || kind == K_STORE) && i_out)
                   || (kind == K_BRANCH && (s < -32'sd4096 || s > 32'sd4094 || imm[0]))
                   || (kind == K_JAL && (s < -32'sd1048576 || s > 32'sd1048574 || imm[0]))
                   || ((kind == K_LUI || kind == K_AUIPC) && imm[31:20] != 12'd0);
`else
   assign range_bad = 1'b0;
`endif
   assign illegal = bad | range_bad;
   assign instr   = illegal ? NOP : raw;
endmodule

// File: rtl/cpu5_instr_encoder.sv
// cpu5_instr_encoder: registered RV32I encoder stream with address counter; CPU5_ENC_RANGE_CHECK_EN enables immediate range checks
module cpu5_instr_encoder
   import cpu5_enc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                 clk,
   input logic                 resetn,
   cpu5_instr_encoder_if.slave bus
);
   logic [31:0]       word;
   logic              illegal;
   logic              accept;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cur_addr;
   cpu5_enc_pack u_pack (
      .kind    (bus.in_kind),
      .funct3  (bus.in_funct3),
      .alt     (bus.in_alt),
      .rd      (bus.in_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .imm     (bus.in_imm),
      .instr   (word),
      .illegal (illegal)
   );
   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign cur_addr     = bus.addr_load ? bus.addr_val : addr_q;
   // output stage, address counter and saturating illegal-descriptor count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_addr  <= '0;
         bus.out_err   <= 1'b0;
         bus.err_cnt   <= '0;
         addr_q        <= BASE_ADDR;
      end else begin
         bus.out_valid <= accept | (bus.out_valid & !bus.out_ready);
         if (accept) begin
            bus.out_instr <= word;
            bus.out_addr  <= cur_addr;
            bus.out_err   <= illegal;
            addr_q        <= cur_addr + ADDR_W'(4);
            if (illegal && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
         end else if (bus.addr_load) begin
            addr_q <= bus.addr_val;
         end
      end
   end
endmodule

// File: doc/cpu5_instr_encoder.md
# cpu5_instr_encoder

Sequential RV32I instruction encoder: the inverse of the cpu5 control decode path. Accepts instruction descriptions (kind, funct3, alt bit, register indices, immediate) over a valid/ready stream. Packs them into 32-bit RV32I words, and presents each word with its target instruction-memory address on an output stream. Used by the boot loader and the test infrastructure to fill instruction memory.

## Interface

Parameters:
- ADDR_W, 32, width of the word-address counter.
- BASE_ADDR, 0, reset and default address of the first word.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_kind  in  4  enc_kind_t: R=0, OPIMM=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8; 9..15 illegal.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  selects sub/sra/srai (instr bit 30).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte offset or immediate; for LUI/AUIPC, imm[19:0] is the upper immediate.
- addr_load  in  1  load addr_val into the address counter.
- addr_val  in  ADDR_W  new address.
- out_valid  out  1  word valid.
- out_ready  in  1  word consumed when out_valid & out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  address of out_instr.
- out_err  out  1  descriptor was illegal; out_instr is a NOP.
- err_cnt  out  8  saturating count of illegal descriptors.

## Operation

- One output register stage.
  - in_ready = !out_valid | out_ready.
  - On accept: out_instr, out_addr and out_err load, and out_valid sets.
  - On output consume with no accept in the same cycle: out_valid clears.
- Field placement follows RV32I:
  - Opcodes: R 0x33, OPIMM 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, JAL 0x6F, JALR 0x67, LUI 0x37, AUIPC 0x17.
  - R: bit 30 = in_alt, all other funct7 bits 0.
  - OPIMM with funct3 1 or 5: shamt = imm[4:0], bit 30 = in_alt, bits 31 and 29:25 = 0.
  - B/J: imm[0] is not encoded.
- Illegal (always checked):
  - kind ≥ 9.
  - LOAD funct3 ∈ {3,6,7}.
  - STORE funct3 > 2.
  - BRANCH funct3 ∈ {2,3}.
  - JALR funct3 ≠ 0.
  - in_alt = 1 with R funct3 ∉ {0,5}.
  - in_alt = 1 with OPIMM funct3 ≠ 5.
  - OPIMM shift with imm outside 0..31.
- Illegal response:
  - out_instr = 0x00000013, out_err = 1, and the word is still emitted.
  - err_cnt increments and saturates at 255.
- Address counter:
  - Each accept uses the current address, then the counter advances by 4, modulo 2^ADDR_W (wraps to 0).
  - Simultaneous addr_load and accept: the accepted word takes addr_val, and the counter becomes addr_val+4.
  - addr_load alone: counter = addr_val.

## Timing

- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle while out_ready is held high.
- Backpressure: while out_valid & !out_ready, out_instr, out_addr and out_err stay stable, and in_ready = 0.
- Reset (any time, including mid-transfer):
  - out_valid = 0, out_instr = 0, out_addr = 0, out_err = 0, err_cnt = 0.
  - Address counter = BASE_ADDR.
  - Any pending word is discarded.
- First accept after reset is allowed in the first cycle with resetn high.

## Configuration

- CPU5_ENC_RANGE_CHECK_EN defined — immediate range checks are also illegal conditions:
  - I/S imm outside −2048..2047.
  - B imm outside −4096..4094, or odd.
  - J imm outside −2^20..2^20−2, or odd.
  - LUI/AUIPC imm[31:20] ≠ 0.
- Undefined: immediates are silently truncated to their field width, and only the always-checked conditions raise out_err.

## Structure

- Shared package cpu5_enc_pkg holds:
  - enc_kind_t.
  - Opcode constants.
  - The NOP constant 0x00000013.
- One combinational sub-module, cpu5_enc_pack: descriptor in; word and illegal flag out.
- The top holds the output register, the address counter and err_cnt.

## Test plan

- Field encodings, back-to-back with out_ready = 1, addr_load=0:
  - addi x1,x0,5 (OPIMM f3=0 rd=1 imm=5) -> 0x00500093 @BASE_ADDR.
  - add x3,x1,x2 -> 0x002081B3 @+4.
  - sub x3,x1,x2 (alt=1) -> 0x402081B3 @+8.
- Store/branch/jump/upper encodings:
  - sw x2,8(x1) -> 0x0020A423.
  - beq x1,x2,+8 -> 0x00208463.
  - jal x1,+16 -> 0x010000EF.
  - lui x5,0x12345 -> 0x123452B7.
- Illegal descriptors:
  - LOAD f3=7 -> out_instr 0x00000013, out_err=1, err_cnt=1.
  - 256 more illegal descriptors -> err_cnt saturates at 255.
- Range check:
  - addi with imm=2048 -> out_err=1 with macro defined.
  - Same descriptor -> 0x80000013, out_err=0 without the macro.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> one word held stable, in_ready=0.
  - Release out_ready -> the queued words are delivered in order at consecutive addresses.
- Address wrap and reset:
  - With ADDR_W=8, addr_load 0xFC on the same cycle as an accept -> word @0xFC, next word @0x00.
  - Assert resetn low mid-stream -> out_valid=0 immediately, and the next word @BASE_ADDR.
